// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a FIFO of words feeding a frame serializer.
// Frame format (start, data LSB first, optional parity, 1 or 2 stop bits)
// and bit period are latched per frame from the config inputs when the
// word is popped, so config changes never disturb a frame on the line.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | line high; pops the next word when the FIFO is non-empty;
//            | the cycle right after a frame is its final stop cycle
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (even: XOR of data, odd: inverted)
//   S_STOP   | stop bits (high); the last one ends one cycle early because
//            | the following IDLE cycle completes it
module uart_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid,
    input  logic [DATA_BITS-1:0]         wr_data,
    output logic                         wr_ready,
    input  logic [DIV_WIDTH-1:0]         divisor,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    output logic                         tx_out,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop, empty;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 par_en_q, par_en_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 two_q, two_d;
    logic                 tx_q, tx_d;
    logic                 tail_q, tail_d;
    logic                 bit_end, go_stop;

    // Full/empty come from the occupancy count so wrapped pointers never alias.
    assign empty    = (count_q == '0);
    assign wr_ready = (count_q != FULL_CNT);
    assign push     = wr_valid && wr_ready;
    assign head     = fifo_mem_q[rd_ptr_q];
    assign bit_end  = (timer_q == div_q);

    assign tx_out     = tx_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || tail_q || !empty;

    // FIFO storage; contents need no reset because the pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serializer state register; tx_out is registered from the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            div_q      <= '0;
            two_q      <= 1'b0;
            tx_q       <= 1'b1;
            tail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            div_q      <= div_d;
            two_q      <= two_d;
            tx_q       <= tx_d;
            tail_q     <= tail_d;
        end
    end

    // Next-state, bit timing and line value for the following cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + DIV_WIDTH'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        div_d      = div_q;
        two_d      = two_q;
        tx_d       = tx_q;
        tail_d     = 1'b0;
        pop        = 1'b0;
        go_stop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    shift_d  = head;
                    parity_d = (^head) ^ (parity_mode == 2'b10);
                    par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    div_d    = divisor;
                    two_d    = two_stop;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d   = '0;
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            go_stop = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    go_stop = 1'b1;
                end
            end
            S_STOP: begin
                if (stop_idx_q == two_q) begin
                    // Last stop bit: the IDLE cycle that follows supplies its final cycle.
                    if (timer_q == div_q - DIV_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                        tail_d  = 1'b1;
                    end
                end else if (bit_end) begin
                    timer_d    = '0;
                    stop_idx_d = 1'b1;
                    if (div_q == '0) begin
                        state_d = S_IDLE;
                        tail_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase

        // With one-cycle bits and a single stop bit, the IDLE cycle is the whole stop bit.
        if (go_stop) begin
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
            if ((div_q == '0) && !two_q) begin
                state_d = S_IDLE;
                tail_d  = 1'b1;
            end else begin
                state_d = S_STOP;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and randomized checks of the buffered UART transmitter against
// a per-cycle line model built from the frame format rules.
module tb_uart_tx_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, wr_valid5;
    logic [7:0]  wr_data;
    logic [4:0]  wr_data5;
    logic        wr_ready, wr_ready5;
    logic [15:0] divisor;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        tx_out, tx_out5;
    logic        busy, busy5;
    logic [4:0]  fifo_count, fifo_count5;

    int          checks = 0;
    int          errors = 0;
    bit          exp_q[$];
    logic [7:0]  wq[$];
    int          kk;
    bit          sel5;
    int          accepted;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .divisor(divisor), .parity_mode(parity_mode),
        .two_stop(two_stop), .tx_out(tx_out), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_buffered #(.DATA_BITS(5), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut5 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid5), .wr_data(wr_data5),
        .wr_ready(wr_ready5), .divisor(divisor), .parity_mode(parity_mode),
        .two_stop(two_stop), .tx_out(tx_out5), .busy(busy5), .fifo_count(fifo_count5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line, one entry per clock: start, data LSB first, parity, stops.
    task automatic model_frame(input logic [7:0] d, input int nb, input int dv,
                               input logic [1:0] pm, input bit two);
        bit p;
        p = 1'b0;
        repeat (dv + 1) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (dv + 1) exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            if (pm == 2'b10) p = ~p;
            repeat (dv + 1) exp_q.push_back(p);
        end
        repeat ((two ? 2 : 1) * (dv + 1)) exp_q.push_back(1'b1);
    endtask

    task automatic start_stream();
        exp_q.delete();
        kk = 0;
    endtask

    task automatic set_wr(input bit v, input logic [7:0] d);
        if (sel5) begin
            wr_valid5 = v;
            wr_data5  = d[4:0];
        end else begin
            wr_valid = v;
            wr_data  = d;
        end
    endtask

    function automatic logic [4:0] cur_count();
        return sel5 ? fifo_count5 : fifo_count;
    endfunction

    // Advance one clock and compare the line and busy against the model.
    task automatic step(input string tag);
        bit eb, bb;
        @(posedge clk);
        #1;
        eb = (kk < exp_q.size()) ? exp_q[kk] : 1'b1;
        bb = (kk < exp_q.size());
        if (sel5) begin
            chk({tag, " tx"}, 32'(tx_out5), 32'(eb));
            chk({tag, " busy"}, 32'(busy5), 32'(bb));
        end else begin
            chk({tag, " tx"}, 32'(tx_out), 32'(eb));
            chk({tag, " busy"}, 32'(busy), 32'(bb));
        end
        kk++;
    endtask

    // Offer the words in wq on consecutive edges and follow the line to the end.
    task automatic send_and_check(input string tag, input int extra);
        int n;
        n = wq.size();
        set_wr(1'b1, wq[0]);
        @(posedge clk);
        #1;
        chk({tag, " cnt0"}, 32'(cur_count()), 32'd1);
        while (kk < exp_q.size() + extra) begin
            if (kk + 1 < n) set_wr(1'b1, wq[kk + 1]);
            else set_wr(1'b0, 8'h00);
            step(tag);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dv, n, s;
        logic [1:0]  pm;
        bit          two;
        logic [7:0]  w;

        reset = 1'b1;
        wr_valid = 1'b0; wr_data = '0; wr_valid5 = 1'b0; wr_data5 = '0;
        divisor = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
        sel5 = 1'b0;
        #1;
        chk("rst tx", 32'(tx_out), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(wr_ready), 32'd1);
        chk("rst cnt", 32'(fifo_count), 32'd0);
        chk("rst tx5", 32'(tx_out5), 32'd1);
        chk("rst cnt5", 32'(fifo_count5), 32'd0);
        #21;
        reset = 1'b0;

        // 0x55, 4-cycle bits, no parity, one stop bit: 40 cycles then idle.
        start_stream();
        model_frame(8'h55, 8, 3, 2'b00, 1'b0);
        wq = '{8'h55};
        send_and_check("t55", 6);

        // Parity even/odd on 0x07, then two stop bits ahead of a queued frame.
        parity_mode = 2'b01;
        start_stream();
        model_frame(8'h07, 8, 3, 2'b01, 1'b0);
        wq = '{8'h07};
        send_and_check("peven", 4);
        parity_mode = 2'b10; two_stop = 1'b1;
        w = 8'($urandom);
        start_stream();
        model_frame(8'h07, 8, 3, 2'b10, 1'b1);
        model_frame(w, 8, 3, 2'b10, 1'b1);
        wq = '{8'h07, w};
        send_and_check("podd2s", 4);

        // Randomized configurations and bursts.
        for (int r = 0; r < 8; r++) begin
            dv = $urandom_range(0, 4);
            pm = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            divisor = 16'(dv); parity_mode = pm; two_stop = two;
            start_stream();
            wq.delete();
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom);
                wq.push_back(w);
                model_frame(w, 8, dv, pm, two);
            end
            send_and_check("rand", 3);
        end

        // Divisor change mid-frame only affects the next frame.
        divisor = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
        start_stream();
        model_frame(8'hC3, 8, 3, 2'b00, 1'b0);
        model_frame(8'h3A, 8, 7, 2'b00, 1'b0);
        set_wr(1'b1, 8'hC3);
        @(posedge clk);
        #1;
        set_wr(1'b0, 8'h00);
        while (kk < exp_q.size() + 4) begin
            if (kk == 12) begin
                divisor = 16'd7;
                set_wr(1'b1, 8'h3A);
            end else begin
                set_wr(1'b0, 8'h00);
            end
            step("divchg");
        end

        // Stream of writes into a 16-deep FIFO: 17 accepted, all sent in order.
        divisor = 16'd433;
        start_stream();
        model_frame(8'd0, 8, 433, 2'b00, 1'b0);
        for (int j = 1; j <= 16; j++) model_frame(8'(j), 8, 3, 2'b00, 1'b0);
        accepted = 0;
        set_wr(1'b1, 8'd0);
        if (wr_ready) accepted++;
        @(posedge clk);
        #1;
        chk("fill cnt0", 32'(fifo_count), 32'd1);
        while (kk < exp_q.size() + 5) begin
            if (kk + 1 <= 31) set_wr(1'b1, 8'(kk + 1));
            else set_wr(1'b0, 8'h00);
            if (wr_valid && wr_ready) accepted++;
            if (kk == 100) divisor = 16'd3;
            step("fill");
            s = kk - 1;
            if (s == 0) chk("fill pushpop cnt", 32'(fifo_count), 32'd1);
            if (s == 14) begin
                chk("fill ready15", 32'(wr_ready), 32'd1);
                chk("fill cnt15", 32'(fifo_count), 32'd15);
            end
            if (s == 15) begin
                chk("fill ready16", 32'(wr_ready), 32'd0);
                chk("fill cnt16", 32'(fifo_count), 32'd16);
            end
        end
        chk("fill accepted", 32'(accepted), 32'd17);

        // Reset during bit 3 of a frame with 5 words queued.
        divisor = 16'd3;
        start_stream();
        for (int j = 0; j < 6; j++) model_frame(8'h00, 8, 3, 2'b00, 1'b0);
        set_wr(1'b1, 8'h00);
        @(posedge clk);
        #1;
        while (kk < 14) begin
            if (kk + 1 < 6) set_wr(1'b1, 8'h00);
            else set_wr(1'b0, 8'h00);
            step("prerst");
        end
        chk("prerst cnt", 32'(fifo_count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst tx", 32'(tx_out), 32'd1);
        chk("arst cnt", 32'(fifo_count), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("hrst tx", 32'(tx_out), 32'd1);
        chk("hrst cnt", 32'(fifo_count), 32'd0);
        #3;
        reset = 1'b0;
        start_stream();
        repeat (20) step("postrst");
        chk("postrst cnt", 32'(fifo_count), 32'd0);
        start_stream();
        model_frame(8'hA5, 8, 3, 2'b00, 1'b0);
        wq = '{8'hA5};
        send_and_check("afterrst", 3);

        // Five-bit instance, one-cycle bits, push and pop on the same edge.
        sel5 = 1'b1;
        divisor = 16'd0; parity_mode = 2'b00; two_stop = 1'b0;
        w = 8'($urandom_range(0, 31));
        start_stream();
        model_frame(8'h1F, 5, 0, 2'b00, 1'b0);
        model_frame(w, 5, 0, 2'b00, 1'b0);
        set_wr(1'b1, 8'h1F);
        @(posedge clk);
        #1;
        chk("d5 cnt0", 32'(fifo_count5), 32'd1);
        set_wr(1'b1, w);
        step("d5");
        chk("d5 pushpop cnt", 32'(fifo_count5), 32'd1);
        set_wr(1'b0, 8'h00);
        while (kk < exp_q.size() + 4) begin
            step("d5");
            s = kk - 1;
            if (s == 6) chk("d5 cnt6", 32'(fifo_count5), 32'd1);
            if (s == 7) chk("d5 cnt7", 32'(fifo_count5), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal values 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of the runtime baud divisor.
REQ-004 SHALL have port clk, input, 1, the single clock (100 MHz); all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1, write request.
REQ-007 SHALL have port wr_data, input, DATA_BITS, the word to send, LSB first.
REQ-008 SHALL have port wr_ready, output, 1, FIFO can accept a word; equals !full.
REQ-009 SHALL have port divisor, input, DIV_WIDTH, cycles per bit minus one (433 gives 230400 baud).
REQ-010 SHALL have port parity_mode, input, 2, parity select: 00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port two_stop, input, 1, selects stop bits: 0 gives one stop bit, 1 gives two.
REQ-012 SHALL have port tx_out, output, 1, serial line; idles high.
REQ-013 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 SHALL accept a word on any rising edge where wr_valid && wr_ready; writes while full are ignored and leave the FIFO unchanged.
REQ-016 SHALL keep fifo_count unchanged on a cycle with a simultaneous push and pop; a push while full is never accepted, even if a pop occurs that cycle.
REQ-017 SHALL use an FSM with the following states and transitions:
- IDLE -> START when the FIFO is non-empty; the pop and the frame-config capture happen on that edge.
- START -> DATA.
- DATA -> PARITY after DATA_BITS bits if parity is enabled, otherwise DATA -> STOP.
- PARITY -> STOP.
- STOP -> IDLE after 1 or 2 stop bits.
REQ-018 SHALL capture divisor, parity_mode and two_stop at frame start (the IDLE->START edge); changes mid-frame take effect only on the next frame.
REQ-019 SHALL hold every bit on tx_out for exactly divisor+1 clk cycles; divisor=0 gives 1 cycle per bit.
REQ-020 SHALL drive tx_out low, for the start bit, on the edge after the pop; with an empty FIFO, the start bit begins 1 cycle after the accepting write edge.
REQ-021 SHALL send data bits LSB first, then the parity bit, then the stop bits (high).
REQ-022 SHALL compute the parity bit as follows: even parity gives XOR of the data bits; odd parity gives its inverse.
REQ-023 SHALL allow back-to-back frames: if the FIFO is non-empty when the last stop bit ends, the next start bit follows immediately with no idle cycle (IDLE is occupied for 1 cycle with tx_out high, which counts as the final stop cycle, i.e. the last stop bit is divisor+1 cycles including that IDLE cycle).
REQ-024 SHALL use a bit-timer counter that resets at every bit boundary and is held at 0 in IDLE.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; full and empty are derived from fifo_count, never from pointer equality alone.
REQ-026 SHALL register tx_out with no combinational path from any input to tx_out.

Reset
REQ-027 SHALL, on reset assertion (asynchronous), immediately force the following, and hold them while reset is high:
- tx_out=1, busy=0, wr_ready=1, fifo_count=0;
- FSM=IDLE, pointers and timer=0.
REQ-028 SHALL discard any frame in progress and all queued words on reset mid-frame; no partial frame resumes after release.
REQ-029 SHALL not start a frame or accept a write until the first rising clk edge after reset deasserts.

Verification
REQ-030 SHALL cover: DATA_BITS=8, divisor=3, parity 00, two_stop=0, write 0x55 -> tx_out 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total), then high; busy falls after the stop bit.
REQ-031 SHALL cover: parity_mode=01, write 0x07 -> parity bit 1; parity_mode=10, write 0x07 -> parity bit 0; two_stop=1 -> 2 stop bits (8 cycles high at divisor=3) before the next start.
REQ-032 SHALL cover: FIFO_DEPTH=16, divisor=433, wr_valid held high from cycle 0 with data 0..31 -> 17 words accepted (first popped at cycle 1), then wr_ready=0 with fifo_count=16; words appear on the line in order 0..16, back-to-back with no idle gap.
REQ-033 SHALL cover: divisor changed from 3 to 7 mid-frame -> the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
REQ-034 SHALL cover: reset asserted during bit 3 of a frame with 5 words queued -> tx_out=1 and fifo_count=0 immediately without a clock edge; after release, the line stays idle high until a new write.
REQ-035 SHALL cover: divisor=0, DATA_BITS=5, write 0x1F -> start bit 1 cycle, 5 one-cycle data bits of 1, stop 1 cycle; a push and pop on the same cycle keeps fifo_count constant.
